// File: rtl/alloc_tracker_pkg.sv
// Shared types and widths for the heap allocation tracker.
// Provides the FSM state enum and a saturating drop-counter increment.
package alloc_tracker_pkg;

    localparam int ADDR_W     = 32;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RET,
        EMIT
    } state_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(
        input logic [DROP_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alloc_bounds_calc.sv
// Combinational object-bounds math: first/last byte, size class, wrap.
// Ports: ptr_i, size_i in; first_o, last_o, is_big_o, wrap_o, valid_o out.
module alloc_bounds_calc
    import alloc_tracker_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BIG_THRESHOLD = 32'd4096
) (
    input  logic [ADDR_W-1:0] ptr_i,
    input  logic [ADDR_W-1:0] size_i,
    output logic [ADDR_W-1:0] first_o,
    output logic [ADDR_W-1:0] last_o,
    output logic              is_big_o,
    output logic              wrap_o,
    output logic              valid_o
);

    logic [ADDR_W:0] sum;

    assign sum      = {1'b0, ptr_i} + {1'b0, size_i};
    assign first_o  = ptr_i;
    assign last_o   = sum[ADDR_W-1:0] - 1'b1;
    assign is_big_o = size_i >= BIG_THRESHOLD;
    assign wrap_o   = sum[ADDR_W];
    // A null pointer means the allocator failed; zero size has no bytes.
    assign valid_o  = (ptr_i != '0) && (size_i != '0) && !wrap_o;

endmodule

// File: rtl/alloc_tracker.sv
// Tracks malloc (and calloc with ALLOC_TRACKER_CALLOC_EN) call/return pairs
// on the commit stream and emits registered object bounds to the bounds
// buffer. Ports: clk_i, rst_ni, clear_i, allocator PCs, commit bundle,
// a0/a1 values in; en_write_o, addr_first_o, addr_last_o, is_big_o,
// busy_o, drop_cnt_o out.
module alloc_tracker
    import alloc_tracker_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BIG_THRESHOLD  = 32'd4096,
    parameter int unsigned       TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [ADDR_W-1:0]     malloc_addr_i,
    input  logic [ADDR_W-1:0]     calloc_addr_i,
    input  logic                  commit_valid_i,
    input  logic [ADDR_W-1:0]     commit_pc_i,
    input  logic [ADDR_W-1:0]     commit_target_i,
    input  logic                  commit_is_call_i,
    input  logic                  commit_is_ret_i,
    input  logic                  commit_is_rvc_i,
    input  logic [ADDR_W-1:0]     rf_a0_i,
    input  logic [ADDR_W-1:0]     rf_a1_i,
    output logic                  en_write_o,
    output logic [ADDR_W-1:0]     addr_first_o,
    output logic [ADDR_W-1:0]     addr_last_o,
    output logic                  is_big_o,
    output logic                  busy_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       size_q, size_d;
    logic [ADDR_W-1:0]       ret_q, ret_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [31:0]             timer_q, timer_d;
    logic                    wr_q, wr_d;
    logic [ADDR_W-1:0]       first_q, first_d;
    logic [ADDR_W-1:0]       last_q, last_d;
    logic                    big_q, big_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic                    drop_inc;

    logic                    call_v;
    logic                    ret_v;
    logic                    malloc_hit;
    logic                    calloc_hit;
    logic                    calloc_ovf;
    logic [ADDR_W-1:0]       calloc_size;
    logic [ADDR_W-1:0]       ret_addr;

    logic [ADDR_W-1:0]       b_first;
    logic [ADDR_W-1:0]       b_last;
    logic                    b_big;
    logic                    b_wrap;
    logic                    b_valid;

    assign call_v     = commit_valid_i & commit_is_call_i;
    assign ret_v      = commit_valid_i & commit_is_ret_i;
    assign malloc_hit = call_v && (commit_target_i == malloc_addr_i);
    assign ret_addr   = commit_pc_i
                      + (commit_is_rvc_i ? 32'd2 : 32'd4);

`ifdef ALLOC_TRACKER_CALLOC_EN
    logic [2*ADDR_W-1:0] prod;

    assign prod        = 64'(rf_a0_i) * 64'(rf_a1_i);
    assign calloc_hit  = call_v && (commit_target_i == calloc_addr_i);
    assign calloc_ovf  = prod[2*ADDR_W-1:ADDR_W] != '0;
    assign calloc_size = prod[ADDR_W-1:0];
`else
    logic unused_calloc;

    assign unused_calloc = ^{calloc_addr_i, rf_a1_i};
    assign calloc_hit    = 1'b0;
    assign calloc_ovf    = 1'b0;
    assign calloc_size   = '0;
`endif

    alloc_bounds_calc #(
        .BIG_THRESHOLD(BIG_THRESHOLD)
    ) u_calc (
        .ptr_i   (ptr_q),
        .size_i  (size_q),
        .first_o (b_first),
        .last_o  (b_last),
        .is_big_o(b_big),
        .wrap_o  (b_wrap),
        .valid_o (b_valid)
    );

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        ret_d    = ret_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        wr_d     = 1'b0;
        first_d  = first_q;
        last_d   = last_q;
        big_d    = big_q;
        drop_inc = 1'b0;

        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // malloc wins if both entry PCs happen to match
                    if (malloc_hit) begin
                        size_d  = rf_a0_i;
                        ret_d   = ret_addr;
                        timer_d = '0;
                        state_d = WAIT_RET;
                    end else if (calloc_hit) begin
                        if (calloc_ovf) begin
                            drop_inc = 1'b1;
                        end else begin
                            size_d  = calloc_size;
                            ret_d   = ret_addr;
                            timer_d = '0;
                            state_d = WAIT_RET;
                        end
                    end
                end
                WAIT_RET: begin
                    timer_d = timer_q + 1'b1;
                    // a match beats a coincident timeout
                    if (ret_v && (commit_target_i == ret_q)) begin
                        ptr_d   = rf_a0_i;
                        state_d = EMIT;
                    end else if (timer_q == TMO_LAST) begin
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                    end
                end
                EMIT: begin
                    state_d = IDLE;
                    if (b_valid) begin
                        wr_d    = 1'b1;
                        first_d = b_first;
                        last_d  = b_last;
                        big_d   = b_big;
                    end else if (b_wrap) begin
                        drop_inc = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        drop_d = drop_inc ? sat_inc(drop_q) : drop_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            size_q  <= '0;
            ret_q   <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            wr_q    <= 1'b0;
            first_q <= '0;
            last_q  <= '0;
            big_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            ret_q   <= ret_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            wr_q    <= wr_d;
            first_q <= first_d;
            last_q  <= last_d;
            big_q   <= big_d;
            drop_q  <= drop_d;
        end
    end

    assign en_write_o   = wr_q;
    assign addr_first_o = first_q;
    assign addr_last_o  = last_q;
    assign is_big_o     = big_q;
    assign busy_o       = state_q != IDLE;
    assign drop_cnt_o   = drop_q;

endmodule
